// File: rtl/xibus_master_seq_if.sv
// Local-bus master sequencer signal bundle: requester handshake, arbiter/target
// inputs and the strobes driven back toward the bus transceivers.
interface xibus_master_seq_if;
    logic       REQ;
    logic       WR;
    logic       GNT;
    logic       ACKL;
    logic [1:0] TMIN;
    logic       ARBL;
    logic       STARTL;
    logic       MASTER;
    logic       ADRCY;
    logic       DTACY;
    logic       TM1L;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic       TOUT;

    modport master (
        input  REQ, WR, GNT, ACKL, TMIN,
        output ARBL, STARTL, MASTER, ADRCY, DTACY, TM1L, BUSY, DONE, ERR, TOUT
    );

    modport slave (
        output REQ, WR, GNT, ACKL, TMIN,
        input  ARBL, STARTL, MASTER, ADRCY, DTACY, TM1L, BUSY, DONE, ERR, TOUT
    );
endinterface

// File: rtl/xibus_master_seq.sv
// Local-bus master transaction sequencer: arbitrate, address load/cycle, data
// cycle with ACKL wait, timeout and bounded target-retry; registered strobes.
module xibus_master_seq #(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic                CLK,
    input  logic                RESETL,
    xibus_master_seq_if.master  bus
);

    // Termination kind is folded into the END state so every output decodes
    // from the state register alone.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_ADR,
        S_DATA,
        S_END_OK,
        S_END_ERR,
        S_END_TO
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] RMAX    = 4'(MAX_RETRY);

    state_t     state, state_nxt;
    logic [7:0] tcnt, tcnt_nxt;
    logic [3:0] rcnt, rcnt_nxt;
    logic       wr_lat, wr_lat_nxt;

    logic arbl_d, startl_d, master_d, adrcy_d, dtacy_d, busy_d, done_d, err_d, tout_d;
    logic arbl_q, startl_q, master_q, adrcy_q, dtacy_q, busy_q, done_q, err_q, tout_q;

    // State, counters, latched direction and registered strobes
    always_ff @(posedge CLK) begin
        if (!RESETL) begin
            state    <= S_IDLE;
            tcnt     <= 8'd0;
            rcnt     <= 4'd0;
            wr_lat   <= 1'b1;
            arbl_q   <= 1'b1;
            startl_q <= 1'b1;
            master_q <= 1'b0;
            adrcy_q  <= 1'b0;
            dtacy_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tcnt     <= tcnt_nxt;
            rcnt     <= rcnt_nxt;
            wr_lat   <= wr_lat_nxt;
            arbl_q   <= arbl_d;
            startl_q <= startl_d;
            master_q <= master_d;
            adrcy_q  <= adrcy_d;
            dtacy_q  <= dtacy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tout_q   <= tout_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_nxt  = state;
        tcnt_nxt   = tcnt;
        rcnt_nxt   = rcnt;
        wr_lat_nxt = wr_lat;
        case (state)
            S_IDLE: begin
                if (bus.REQ) begin
                    wr_lat_nxt = bus.WR;
                    rcnt_nxt   = 4'd0;
                    state_nxt  = S_ARB;
                end
            end
            S_ARB: begin
                if (bus.GNT) state_nxt = S_LOAD;
            end
            S_LOAD: state_nxt = S_ADR;
            S_ADR: begin
                tcnt_nxt  = 8'd0;
                state_nxt = S_DATA;
            end
            S_DATA: begin
                // An acknowledge on the final timeout clock still completes.
                if (!bus.ACKL) begin
                    case (bus.TMIN)
                        2'b00:   state_nxt = S_END_OK;
                        2'b11: begin
                            if (rcnt < RMAX) begin
                                rcnt_nxt  = rcnt + 4'd1;
                                state_nxt = S_ARB;
                            end else begin
                                state_nxt = S_END_ERR;
                            end
                        end
                        default: state_nxt = S_END_ERR;
                    endcase
                end else if (tcnt == TO_LAST) begin
                    state_nxt = S_END_TO;
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                end
            end
            S_END_OK, S_END_ERR, S_END_TO: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, captured into the output flops
    always_comb begin
        arbl_d   = 1'b1;
        startl_d = 1'b1;
        master_d = 1'b0;
        adrcy_d  = 1'b0;
        dtacy_d  = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tout_d   = 1'b0;
        case (state_nxt)
            S_IDLE:  busy_d = 1'b0;
            S_ARB:   arbl_d = 1'b0;
            S_LOAD:  master_d = 1'b1;
            S_ADR: begin
                master_d = 1'b1;
                adrcy_d  = 1'b1;
                startl_d = 1'b0;
            end
            S_DATA: begin
                master_d = 1'b1;
                dtacy_d  = 1'b1;
            end
            S_END_OK: done_d = 1'b1;
            S_END_ERR: begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            S_END_TO: begin
                done_d = 1'b1;
                err_d  = 1'b1;
                tout_d = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    assign bus.ARBL   = arbl_q;
    assign bus.STARTL = startl_q;
    assign bus.MASTER = master_q;
    assign bus.ADRCY  = adrcy_q;
    assign bus.DTACY  = dtacy_q;
    assign bus.TM1L   = wr_lat;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.ERR    = err_q;
    assign bus.TOUT   = tout_q;

endmodule

// File: tb/tb_xibus_master_seq.sv
// Bench for xibus_master_seq: table of directed transactions, hand-written reset
// and back-to-back sequences, then random transactions against a transaction model.
module tb_xibus_master_seq;

    localparam int TO   = 8;
    localparam int MAXR = 3;
    localparam logic [9:0] RST_VEC = 10'b11_000_1_0000;

    logic CLK = 1'b0;
    logic RESETL;
    int   total = 0;
    int   bad   = 0;

    xibus_master_seq_if bus ();

    xibus_master_seq #(.TIMEOUT_CYC(TO), .MAX_RETRY(MAXR)) dut (
        .CLK   (CLK),
        .RESETL(RESETL),
        .bus   (bus.master)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic            wr;
        logic [4:0][7:0] gd;
        logic [4:0][7:0] aw;
        logic [4:0][1:0] st;
        int              e_done;
        int              e_err;
        int              e_tout;
        int              e_arb;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [39:0] gd, input logic [39:0] aw,
                                input logic [9:0] st, input int d, input int e, input int t,
                                input int a);
        vec_t v;
        v.wr = wr; v.gd = gd; v.aw = aw; v.st = st;
        v.e_done = d; v.e_err = e; v.e_tout = t; v.e_arb = a;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {bus.ARBL, bus.STARTL, bus.MASTER, bus.ADRCY, bus.DTACY,
                bus.TM1L, bus.BUSY, bus.DONE, bus.ERR, bus.TOUT};
    endfunction

    // Transaction-level reference: each attempt costs arbitration (gd+1), load,
    // address and its data clocks; the outcome follows the status/timeout rules.
    task automatic model(input logic [4:0][7:0] gd, input logic [4:0][7:0] aw,
                         input logic [4:0][1:0] st, output int done, output int err,
                         output int tout, output int att, output int dcyc, output int acyc);
        int t = 0;
        int retries = 0;
        bit fin = 0;
        err = 0; tout = 0; att = 0; dcyc = 0; acyc = 0;
        for (int i = 0; i < 5 && !fin; i++) begin
            att  = i + 1;
            acyc += int'(gd[i]) + 1;
            t    += int'(gd[i]) + 3;
            if (int'(aw[i]) >= TO) begin
                dcyc += TO; t += TO; err = 1; tout = 1; fin = 1;
            end else begin
                dcyc += int'(aw[i]) + 1;
                t    += int'(aw[i]) + 1;
                if (st[i] == 2'b00) fin = 1;
                else if (st[i] != 2'b11) begin err = 1; fin = 1; end
                else if (retries < MAXR) retries++;
                else begin err = 1; fin = 1; end
            end
        end
        done = t + 1;
    endtask

    task automatic run_txn(input string nm, input logic wr, input logic [4:0][7:0] gd,
                           input logic [4:0][7:0] aw, input logic [4:0][1:0] st,
                           input int e_done, input int e_err, input int e_tout, input int e_arb);
        int m_done, m_err, m_tout, m_att, m_dcyc, m_acyc;
        int cyc = 0, arb_n = 0, att = 0, k = 0, d = 0;
        int dt = 0, ad = 0, sl = 0, ms = 0, alow = 0, viol = 0;
        int got_err = -1, got_tout = -1;
        logic prev_arbl = 1'b1;
        bit done_seen = 0;
        model(gd, aw, st, m_done, m_err, m_tout, m_att, m_dcyc, m_acyc);
        @(posedge CLK); #1;
        check({nm, " idle_before"}, 32'(bus.BUSY), 32'd0);
        bus.REQ = 1'b1; bus.WR = wr;
        bus.GNT = 1'($urandom); bus.ACKL = 1'($urandom); bus.TMIN = 2'($urandom);
        while (!done_seen && cyc < 200) begin
            @(posedge CLK); #1;
            cyc++;
            if (!bus.ARBL && prev_arbl) begin
                arb_n++; att = (arb_n > 5) ? 4 : arb_n - 1; k = 0; d = 0;
            end
            prev_arbl = bus.ARBL;
            if (!bus.ARBL) begin k++; alow++; end
            if (bus.DTACY) begin d++; dt++; end
            if (bus.ADRCY) ad++;
            if (!bus.STARTL) sl++;
            if (bus.MASTER) ms++;
            if (!bus.STARTL && !bus.ADRCY) viol++;
            if (bus.ADRCY && bus.DTACY) viol++;
            if (!bus.MASTER && (bus.ADRCY || bus.DTACY)) viol++;
            if (!bus.ARBL && bus.MASTER) viol++;
            if (bus.TM1L !== wr) viol++;
            if (!bus.DONE && (bus.ERR || bus.TOUT)) viol++;
            if (bus.BUSY !== 1'b1) viol++;
            if (bus.DONE) begin
                done_seen = 1; got_err = int'(bus.ERR); got_tout = int'(bus.TOUT);
            end else begin
                bus.GNT  = !bus.ARBL ? (k > int'(gd[att])) : 1'($urandom);
                bus.ACKL = bus.DTACY ? !(d > int'(aw[att])) : 1'($urandom);
                bus.TMIN = bus.DTACY ? st[att] : 2'($urandom);
                bus.REQ  = 1'($urandom);
                bus.WR   = 1'($urandom);
            end
        end
        bus.REQ = 1'b0; bus.GNT = 1'b0; bus.ACKL = 1'b1;
        check({nm, " done_cycle"}, done_seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(e_done));
        check({nm, " err"},  32'(got_err),  32'(e_err));
        check({nm, " tout"}, 32'(got_tout), 32'(e_tout));
        check({nm, " arb_entries"}, 32'(arb_n), 32'(e_arb));
        check({nm, " arbl_low_clocks"}, 32'(alow), 32'(m_acyc));
        check({nm, " dtacy_clocks"}, 32'(dt), 32'(m_dcyc));
        check({nm, " adrcy_clocks"}, 32'(ad), 32'(m_att));
        check({nm, " startl_clocks"}, 32'(sl), 32'(m_att));
        check({nm, " master_clocks"}, 32'(ms), 32'(2 * m_att + m_dcyc));
        check({nm, " strobe_rules"}, 32'(viol), 32'd0);
    endtask

    vec_t tbl[9];

    initial begin
        int cyc;
        int m_done, m_err, m_tout, m_att, m_dcyc, m_acyc;
        logic [4:0][7:0] gd, aw;
        logic [4:0][1:0] st;

        tbl[0] = mk(1'b0, 40'h0, 40'h0, 10'b00_00_00_00_00, 5, 0, 0, 1);
        tbl[1] = mk(1'b1, {32'h0, 8'd4}, {32'h0, 8'd3}, {8'b0, 2'b01}, 12, 1, 0, 1);
        tbl[2] = mk(1'b0, 40'h0, {32'h0, 8'd8}, 10'b0, 12, 1, 1, 1);
        tbl[3] = mk(1'b0, 40'h0, {32'h0, 8'd7}, 10'b0, 12, 0, 0, 1);
        tbl[4] = mk(1'b0, 40'h0, 40'h0, 10'b00_00_11_11_11, 17, 0, 0, 4);
        tbl[5] = mk(1'b1, 40'h0, 40'h0, 10'b00_11_11_11_11, 17, 1, 0, 4);
        tbl[6] = mk(1'b1, {32'h0, 8'd1}, {32'h0, 8'd2}, {8'b0, 2'b10}, 8, 1, 0, 1);
        tbl[7] = mk(1'b0, 40'h0, {24'h0, 8'd9, 8'd0}, {6'b0, 2'b00, 2'b11}, 16, 1, 1, 2);
        tbl[8] = mk(1'b1, {24'h0, 8'd2, 8'd1}, {24'h0, 8'd1, 8'd0}, {6'b0, 2'b00, 2'b11}, 13, 0, 0, 2);

        // Reset held two clocks with REQ asserted
        RESETL = 1'b0;
        bus.REQ = 1'b1; bus.WR = 1'b0; bus.GNT = 1'b1; bus.ACKL = 1'b0; bus.TMIN = 2'b00;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            check($sformatf("reset_outputs_%0d", i), 32'(outs()), 32'(RST_VEC));
        end
        bus.REQ = 1'b0;
        RESETL = 1'b1;
        @(posedge CLK); #1;
        check("idle_after_reset", 32'(outs()), 32'(RST_VEC));

        for (int i = 0; i < 9; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].gd, tbl[i].aw, tbl[i].st,
                    tbl[i].e_done, tbl[i].e_err, tbl[i].e_tout, tbl[i].e_arb);

        // Reset in the middle of a read data phase
        @(posedge CLK); #1;
        bus.REQ = 1'b1; bus.WR = 1'b0; bus.GNT = 1'b1; bus.ACKL = 1'b1;
        @(posedge CLK); #1;
        bus.REQ = 1'b0;
        cyc = 0;
        while (!bus.DTACY && cyc < 20) begin
            @(posedge CLK); #1; cyc++;
        end
        check("reach_data_before_reset", 32'(bus.DTACY), 32'd1);
        RESETL = 1'b0;
        @(posedge CLK); #1;
        check("reset_in_data_outputs", 32'(outs()), 32'(RST_VEC));
        RESETL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check($sformatf("no_done_after_reset_%0d", i), 32'({bus.DONE, bus.BUSY}), 32'd0);
        end
        run_txn("post_reset", 1'b0, 40'h0, 40'h0, 10'b0, 5, 0, 0, 1);

        // REQ held high: one IDLE clock separates the two transactions
        @(posedge CLK); #1;
        bus.REQ = 1'b1; bus.WR = 1'b1; bus.GNT = 1'b1; bus.ACKL = 1'b0; bus.TMIN = 2'b00;
        cyc = 0;
        do begin
            @(posedge CLK); #1; cyc++;
        end while (!bus.DONE && cyc < 30);
        check("b2b_first_done_cycle", 32'(cyc), 32'd5);
        @(posedge CLK); #1;
        check("b2b_idle_gap_busy", 32'(bus.BUSY), 32'd0);
        @(posedge CLK); #1;
        check("b2b_second_arb", 32'({bus.ARBL, bus.TM1L, bus.BUSY}), 32'b011);
        bus.REQ = 1'b0;
        cyc = 0;
        while (!bus.DONE && cyc < 30) begin
            @(posedge CLK); #1; cyc++;
        end
        check("b2b_second_done", 32'({bus.DONE, bus.ERR, bus.TOUT}), 32'b100);

        // Random transactions scored against the transaction model
        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 5; j++) begin
                int r;
                gd[j] = 8'($urandom_range(0, 4));
                aw[j] = 8'($urandom_range(0, 9));
                r = int'($urandom_range(0, 9));
                st[j] = (r < 4) ? 2'b11 : (r < 7) ? 2'b00 : (r < 8) ? 2'b01 : 2'b10;
            end
            model(gd, aw, st, m_done, m_err, m_tout, m_att, m_dcyc, m_acyc);
            run_txn($sformatf("rnd%0d", n), 1'($urandom), gd, aw, st,
                    m_done, m_err, m_tout, m_att);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xibus_master_seq.md
Name: xibus_master_seq

Overview:
Master-side transaction sequencer for the card's local bus interface. It arbitrates for the bus and steps through address-load, address-cycle and data-cycle phases. It generates the MASTER/ADRCY/DTACY/TM1L strobes that the card's transceiver/register decode consumes. It waits for the target acknowledge and reports status back to the local requester, with timeout and bounded retry.

Parameters:
TIMEOUT_CYC, 255, data-cycle clocks without ACKL before the sequencer aborts with a timeout (1..255)
MAX_RETRY, 3, target-retry responses tolerated before the sequencer reports an error (0..15)

Ports:
CLK      in   1  clock; all state changes on the rising edge
RESETL   in   1  reset; synchronous, active-low
REQ      in   1  local transfer request (level); accepted only in IDLE
WR       in   1  direction; 1 = write, 0 = read; sampled together with REQ
GNT      in   1  bus grant from arbiter
ACKL     in   1  target acknowledge, active-low
TMIN     in   2  target status, valid when ACKL=0: 00 ok, 01 error, 10 bus timeout, 11 retry
ARBL     out  1  arbitration request, active-low
STARTL   out  1  transaction start, active-low; asserted only during the address cycle
MASTER   out  1  card owns a master transaction
ADRCY    out  1  address cycle strobe
DTACY    out  1  data cycle strobe
TM1L     out  1  transfer mode to bus; 1 = write, 0 = read (latched WR)
BUSY     out  1  sequencer is not in IDLE
DONE     out  1  one-clock pulse at transaction end
ERR      out  1  with DONE: target error, bus timeout or retry exhaustion
TOUT     out  1  with DONE: local timeout (no ACKL within TIMEOUT_CYC)

Behaviour:
- Reset (RESETL=0 at a rising edge): state IDLE; ARBL=1, STARTL=1, TM1L=1; MASTER, ADRCY, DTACY, BUSY, DONE, ERR, TOUT=0; timeout and retry counters=0. Reset mid-transaction aborts at once; no DONE is issued.
- Outputs are registered; each is a pure function of the state register plus the latched WR.
- IDLE: if REQ=1, latch WR into TM1L, clear the retry counter and go to ARB. REQ is ignored in all other states.
- ARB: ARBL=0, BUSY=1. Wait for GNT=1, then go to LOAD. ARBL stays low until LOAD is entered. No timeout applies in ARB.
- LOAD, exactly 1 clock: MASTER=1, ADRCY=0, DTACY=0 (address register drives), ARBL=1. Go to ADR.
- ADR, exactly 1 clock: MASTER=1, ADRCY=1, STARTL=0. Go to DATA and clear the timeout counter.
- DATA: MASTER=1, DTACY=1. The timeout counter increments each clock while ACKL=1.
  - On ACKL=0, TMIN decides: 00 -> END ok; 01 or 10 -> END with ERR; 11 -> retry handling.
  - Retry handling: if retry counter < MAX_RETRY, increment it and go to ARB. Otherwise go to END with ERR.
  - If the counter reaches TIMEOUT_CYC while ACKL=1, go to END with ERR=1 and TOUT=1.
  - ACKL=0 on the same clock the counter hits TIMEOUT_CYC: the ACK wins.
- END, 1 clock: MASTER=0, DONE=1, ERR/TOUT valid, BUSY=1. Go to IDLE. A new REQ is sampled only in IDLE, so back-to-back requests see at least one IDLE clock.
- ERR and TOUT are 0 whenever DONE=0.
- MAX_RETRY=0: the first retry response goes directly to END with ERR.
- Read latency with GNT already high and an immediate ACK: REQ seen in IDLE at clock 0, ARB at 1, LOAD at 2, ADR at 3, DATA at 4 with ACKL=0, DONE at 5.
- ADRCY and DTACY are never 1 together. MASTER=1 only in LOAD, ADR and DATA.

Test Plan:
- Reset: hold RESETL=0 for 2 clocks with REQ=1 -> all outputs at reset values, BUSY=0, no ARBL assertion.
- Read, GNT=1, ACKL=0 with TMIN=00 on the first DATA clock -> TM1L=0; ADRCY 1 clock, STARTL low 1 clock; DONE at clock 5; ERR=0.
- Write, GNT delayed 4 clocks, ACK after 3 DATA clocks with TMIN=01 -> ARBL low for 5 clocks, TM1L=1, DONE with ERR=1, TOUT=0.
- Timeout: TIMEOUT_CYC=8, ACKL held high -> DTACY high exactly 8 clocks, then DONE with ERR=1, TOUT=1. Also drive ACKL=0 on the 8th clock -> normal completion, TOUT=0.
- Retry: TMIN=11 three times, then 00 (MAX_RETRY=3) -> three ARB re-entries, DONE with ERR=0. Four retries -> DONE with ERR=1.
- RESETL=0 during DATA -> the next clock shows IDLE outputs, no DONE pulse; a new REQ afterwards completes normally.
